rmux_sel_arb: RTL and testbench
===============================

# rmux_sel_arb

Two-requester arbiter and sequencer for the register-read AOI mux stage (RN = NOT((A AND RA) OR (D AND RD))). It owns the RA/RD select strobes and shares the mux between an A-side and a D-side requester. Grants are round-robin and burst-length controlled. A break-before-make gap between owners guarantees RA and RD are never high together, which would wire-OR both operands onto RN.

## Interface
Parameters:
- BURST_W, 4, width of the burst-length fields (burst = LEN+1 beats, 1..2^BURST_W)
- GAP, 1, dead cycles with RA=RD=0 after every burst; legal range 1..7

Ports:
- sysclk  in  1  system clock, all state on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- REQ_A  in  1  A-side request; level, held until DONE_A
- LEN_A  in  BURST_W  A-side burst length minus one, sampled at grant edge
- REQ_D  in  1  D-side request; level, held until DONE_D
- LEN_D  in  BURST_W  D-side burst length minus one, sampled at grant edge
- GNT_A  out  1  A-side owns the mux
- GNT_D  out  1  D-side owns the mux
- DONE_A  out  1  one-cycle pulse on the final A beat
- DONE_D  out  1  one-cycle pulse on the final D beat
- RA  out  1  mux select for operand A, equal to GNT_A
- RD  out  1  mux select for operand D, equal to GNT_D
- BUSY  out  1  high in OWN_A, OWN_D or GAP

## Operation
- All outputs are registered, with no combinational path from inputs to outputs.
- States: IDLE, OWN_A, OWN_D, GAP.
- Beat counter is BURST_W bits wide. Gap counter is 3 bits wide.
- LAST register holds the owner of the previous burst. Reset value is D, so A wins the first tie.

Arbitration point (in IDLE, or in the final GAP cycle):
- Only REQ_A high: go to OWN_A.
- Only REQ_D high: go to OWN_D.
- Both high: grant the side that is not LAST.
- Neither high: go to or stay in IDLE.

Other transitions:
- On grant: load the beat counter with the LEN of the granted side and update LAST.
- OWN_x: decrement the beat counter each cycle. When it reaches 0, assert DONE_x in that cycle, then go to GAP.
- Abort: in OWN_x, if REQ_x is sampled low before the count reaches 0, go to GAP next cycle with no DONE_x. LAST is still updated.
- GAP: load GAP-1 on entry and decrement. The last GAP cycle is the arbitration point.

Invariants:
- RA and RD are never simultaneously 1.
- RA and RD are 0 in IDLE and GAP.
- DONE_x implies GNT_x in the same cycle.
- LEN inputs are ignored outside the grant edge.

## Timing
- Reset (asynchronous, any state, including mid-burst): GNT_A, GNT_D, RA, RD, DONE_A, DONE_D and BUSY all go to 0 immediately. State becomes IDLE and LAST becomes D. No DONE is issued for an interrupted burst.
- Grant latency: if REQ_x is sampled high at edge n in IDLE, then GNT_x, RA/RD and BUSY are high from n+1.
- Burst: GNT_x is high for exactly LEN_x+1 cycles (edges n+1 .. n+1+LEN_x). DONE_x is high only in cycle n+1+LEN_x.
- LEN=0: a single grant cycle, with DONE asserted in that same cycle.
- Gap: exactly GAP cycles with RA=RD=0 follow every burst or abort. The next grant can start at cycle n+2+LEN+GAP at the earliest.
- Back-to-back: a request still pending at the last GAP cycle is granted with no extra IDLE cycle.
- Abort latency: REQ_x sampled low at edge m inside OWN_x means GNT_x is low from m+1.
- A new REQ arriving during a burst waits. It is never preempted by or merged into the current burst.
- A REQ that goes low before being granted is dropped, with no error reported.

## Test plan
- Reset, then REQ_A=1 with LEN_A=3 held: GNT_A/RA high for 4 cycles starting 1 cycle after sampling, DONE_A on the 4th, then GAP=1 dead cycle, then IDLE with BUSY=0.
- REQ_A and REQ_D both raised at the same edge after reset, LEN_A=LEN_D=0, both held after DONE: expect the sequence A, gap, D, gap, A, with one grant cycle each. RA&RD is never 1.
- GAP=3, REQ_D with LEN_D=2 and REQ_A pending throughout: RD high 3 cycles, then RA=RD=0 for exactly 3 cycles, then RA high on the next cycle.
- Abort: REQ_A with LEN_A=15 deasserted after 5 grant cycles: GNT_A falls on the following edge, no DONE_A, GAP entered. A pending REQ_D is then granted, since A was last.
- Async reset asserted mid-burst (LEN_D=7, beat 4): RD, GNT_D and BUSY drop before the next clock edge. After release with REQ_A and REQ_D both high, A is granted first.
- LEN_A=0 repeated with REQ_A held continuously and REQ_D low: grants recur every 1+GAP cycles, and DONE_A pulses every grant.

Source files
------------

// File: rtl/rmux_sel_arb.sv
// Round-robin, burst-length arbiter owning the RA/RD selects of the register-read AOI mux.
// A break-before-make gap after every burst keeps RA and RD from ever overlapping.
module rmux_sel_arb #(
    parameter int BURST_W = 4,
    parameter int GAP     = 1
) (
    input  logic               sysclk,
    input  logic               sys_rst_n,
    input  logic               REQ_A,
    input  logic [BURST_W-1:0] LEN_A,
    input  logic               REQ_D,
    input  logic [BURST_W-1:0] LEN_D,
    output logic               GNT_A,
    output logic               GNT_D,
    output logic               DONE_A,
    output logic               DONE_D,
    output logic               RA,
    output logic               RD,
    output logic               BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN_A,
        S_OWN_D,
        S_GAP
    } state_t;

    localparam logic [2:0] GAP_LOAD = 3'(GAP - 1);

    state_t             state, state_nx;
    logic [BURST_W-1:0] beat, beat_nx;
    logic [2:0]         gap_cnt, gap_nx;
    logic               last_d, last_d_nx;   // 1: D owned the previous burst
    logic               win_a, win_d, arb;

    always_comb begin
        state_nx  = state;
        beat_nx   = beat;
        gap_nx    = gap_cnt;
        last_d_nx = last_d;
        win_a     = REQ_A && (!REQ_D || last_d);
        win_d     = REQ_D && (!REQ_A || !last_d);
        arb       = (state == S_IDLE) || ((state == S_GAP) && (gap_cnt == '0));

        case (state)
            S_OWN_A: begin
                if ((beat == '0) || !REQ_A) begin
                    state_nx = S_GAP;
                    gap_nx   = GAP_LOAD;
                end else begin
                    beat_nx = beat - BURST_W'(1);
                end
            end
            S_OWN_D: begin
                if ((beat == '0) || !REQ_D) begin
                    state_nx = S_GAP;
                    gap_nx   = GAP_LOAD;
                end else begin
                    beat_nx = beat - BURST_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt != '0) begin
                    gap_nx = gap_cnt - 3'd1;
                end
            end
            default: ;
        endcase

        // IDLE and the final gap cycle share one arbitration point
        if (arb) begin
            if (win_a) begin
                state_nx  = S_OWN_A;
                beat_nx   = LEN_A;
                last_d_nx = 1'b0;
            end else if (win_d) begin
                state_nx  = S_OWN_D;
                beat_nx   = LEN_D;
                last_d_nx = 1'b1;
            end else begin
                state_nx = S_IDLE;
            end
        end
    end

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= S_IDLE;
            beat    <= '0;
            gap_cnt <= '0;
            last_d  <= 1'b1;
            GNT_A   <= 1'b0;
            GNT_D   <= 1'b0;
            DONE_A  <= 1'b0;
            DONE_D  <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_nx;
            beat    <= beat_nx;
            gap_cnt <= gap_nx;
            last_d  <= last_d_nx;
            GNT_A   <= (state_nx == S_OWN_A);
            GNT_D   <= (state_nx == S_OWN_D);
            DONE_A  <= (state_nx == S_OWN_A) && (beat_nx == '0);
            DONE_D  <= (state_nx == S_OWN_D) && (beat_nx == '0);
            BUSY    <= (state_nx != S_IDLE);
        end
    end

    assign RA = GNT_A;
    assign RD = GNT_D;

endmodule

// File: tb/tb_rmux_sel_arb.sv
// Randomized scoreboard bench for rmux_sel_arb: a time-window burst model predicts each
// cycle's outputs into a queue, and a negedge monitor pops and compares.
module tb_rmux_sel_arb;
    localparam int BW = 4;
    localparam int GP = 2;

    logic          sysclk = 1'b0;
    logic          sys_rst_n;
    logic          REQ_A, REQ_D;
    logic [BW-1:0] LEN_A, LEN_D;
    logic          GNT_A, GNT_D, DONE_A, DONE_D, RA, RD, BUSY;

    rmux_sel_arb #(.BURST_W(BW), .GAP(GP)) dut (
        .sysclk(sysclk), .sys_rst_n(sys_rst_n),
        .REQ_A(REQ_A), .LEN_A(LEN_A), .REQ_D(REQ_D), .LEN_D(LEN_D),
        .GNT_A(GNT_A), .GNT_D(GNT_D), .DONE_A(DONE_A), .DONE_D(DONE_D),
        .RA(RA), .RD(RD), .BUSY(BUSY)
    );

    always #5 sysclk = ~sysclk;

    typedef struct packed {
        logic gnt_a, gnt_d, done_a, done_d, busy;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Burst model: owner (0 none, 1 A, 2 D) plus the cycle windows it occupies.
    // Cycle c is the interval following rising edge c.
    int own, last_own, b_start, b_end, done_cyc, arb_edge, cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset(input int next_edge);
        own      = 0;
        last_own = 2;
        b_start  = -1000;
        b_end    = -1000;
        done_cyc = -1000;
        arb_edge = next_edge;
    endtask

    task automatic model_grant(input int side, input int len, input int e);
        own      = side;
        last_own = side;
        b_start  = e;
        b_end    = e + len;
        done_cyc = b_end;
        arb_edge = b_end + GP + 1;
    endtask

    task automatic model_edge(input int e);
        logic ga, gd, rq;
        if (own != 0 && e > b_start && e <= b_end) begin
            rq = (own == 1) ? REQ_A : REQ_D;
            if (!rq) begin
                b_end    = e - 1;
                done_cyc = -1000;
                arb_edge = e + GP;
            end
        end
        if (e >= arb_edge) begin
            ga = REQ_A && (!REQ_D || last_own == 2);
            gd = REQ_D && (!REQ_A || last_own == 1);
            if (ga)      model_grant(1, int'(LEN_A), e);
            else if (gd) model_grant(2, int'(LEN_D), e);
        end
    endtask

    function automatic exp_t model_out(input int c);
        exp_t x;
        logic act;
        act      = (own != 0) && (c >= b_start) && (c <= b_end);
        x.gnt_a  = act && own == 1;
        x.gnt_d  = act && own == 2;
        x.done_a = x.gnt_a && c == done_cyc;
        x.done_d = x.gnt_d && c == done_cyc;
        x.busy   = (own != 0) && (c >= b_start) && (c <= b_end + GP);
        return x;
    endfunction

    // Requester behaviour follows the model's view of grants, never the DUT's.
    task automatic drive_side(input logic gnt, input logic done, inout logic req, output logic [BW-1:0] len);
        if (gnt) begin
            if (done)                         req = ($urandom_range(0, 99) < 50);
            else if ($urandom_range(0, 99) < 3) req = 1'b0;
        end else if (req) begin
            if ($urandom_range(0, 99) < 2) req = 1'b0;
        end else if ($urandom_range(0, 99) < 30) begin
            req = 1'b1;
        end
        len = ($urandom_range(0, 99) < 10) ? BW'($urandom) : BW'($urandom_range(0, 3));
    endtask

    always @(negedge sysclk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gnt_a",  GNT_A,  e.gnt_a);
            check("gnt_d",  GNT_D,  e.gnt_d);
            check("ra",     RA,     e.gnt_a);
            check("rd",     RD,     e.gnt_d);
            check("done_a", DONE_A, e.done_a);
            check("done_d", DONE_D, e.done_d);
            check("busy",   BUSY,   e.busy);
            check("ra_rd_excl", RA & RD, 0);
        end
    end

    initial begin
        exp_t     x;
        logic     in_reset;
        logic     ra_, rd_;
        logic [BW-1:0] la, ld;
        REQ_A = 1'b0; REQ_D = 1'b0; LEN_A = '0; LEN_D = '0;
        sys_rst_n = 1'b0;
        in_reset  = 1'b0;
        cyc       = 0;
        model_reset(1);
        repeat (2) @(posedge sysclk);
        #1;
        check("rst_gnt_a", GNT_A, 0);
        check("rst_gnt_d", GNT_D, 0);
        check("rst_busy",  BUSY,  0);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            @(posedge sysclk);
            #1;
            cyc++;
            if (in_reset) begin
                in_reset  = 1'b0;
                sys_rst_n = 1'b1;
                model_reset(cyc + 1);
            end else begin
                model_edge(cyc);
            end
            x = model_out(cyc);
            if (i > 50 && x.gnt_a | x.gnt_d && $urandom_range(0, 249) == 0) begin
                // async reset mid-burst: outputs must fall before the next edge
                sys_rst_n = 1'b0;
                #1;
                check("arst_gnt_a", GNT_A, 0);
                check("arst_gnt_d", GNT_D, 0);
                check("arst_ra",    RA,    0);
                check("arst_rd",    RD,    0);
                check("arst_busy",  BUSY,  0);
                check("arst_done",  DONE_A | DONE_D, 0);
                in_reset = 1'b1;
                model_reset(cyc + 2);
                x = '0;
                REQ_A = 1'b1;
                REQ_D = 1'b1;
                exp_q.push_back(x);
            end else begin
                exp_q.push_back(x);
                ra_ = REQ_A;
                rd_ = REQ_D;
                drive_side(x.gnt_a, x.done_a, ra_, la);
                drive_side(x.gnt_d, x.done_d, rd_, ld);
                REQ_A = ra_; LEN_A = la;
                REQ_D = rd_; LEN_D = ld;
            end
        end

        @(negedge sysclk);
        #1;
        check("queue_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
